// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types and constants for the display multiplexer
package display_pkg;

    typedef enum logic [1:0] {
        SHOW0 = 2'd0,
        GAP0  = 2'd1,
        SHOW1 = 2'd2,
        GAP1  = 2'd3
    } mux_state_t;

    // Any code >= 16 is rendered dark by the segment decoder.
    localparam logic [4:0] BLANK_CODE = 5'b11111;

endpackage

// File: rtl/mux_dwell_timer.sv
// rtl/mux_dwell_timer.sv - up counter with programmable limit and terminal count
//
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   clear        synchronous clear to zero (state change or display forced dark)
//   limit        terminal value for the current phase
//   tc           high while the count equals limit
module mux_dwell_timer #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic [CW-1:0] limit,
    output logic          tc
);

    logic [CW-1:0] cnt;

    assign tc = (cnt == limit);

    // Holding at the limit keeps the counter from wrapping even if the
    // owner were ever to skip the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (!tc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/display_mux_sched.sv
// rtl/display_mux_sched.sv - dual seven-segment time-multiplex scheduler
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   enable                1 = multiplex running, 0 = display forced dark
//   load_valid/ready      handshake for a new digit pair
//   first_in, second_in   digit codes (0-15 hex, bit4 set = blank)
//   seg_code              code to the shared segment decoder
//   anode_n               active-low digit enables (bit0 = digit 0)
//   frame_done            one-cycle pulse on the first cycle of SHOW0 (commit point)
module display_mux_sched
    import display_pkg::*;
#(
    parameter int DWELL_CYCLES = 24000,
    parameter int GAP_CYCLES   = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [4:0] first_in,
    input  logic [4:0] second_in,
    output logic [4:0] seg_code,
    output logic [1:0] anode_n,
    output logic       frame_done
);

    localparam int MAX_CYCLES = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] DWELL_LIMIT = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LIMIT   = CW'(GAP_CYCLES - 1);

    mux_state_t    state, state_next;
    logic          timer_clear;
    logic [CW-1:0] timer_limit;
    logic          timer_tc;
    logic          commit;
    logic          pending;
    logic [9:0]    shadow;
    logic [4:0]    disp0, disp1;
    logic          frame_done_q;
    logic          accept;

    mux_dwell_timer #(.CW(CW)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (timer_clear),
        .limit (timer_limit),
        .tc    (timer_tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= GAP1;
        end else begin
            state <= state_next;
        end
    end

    // Disabling parks the FSM in GAP1 with the timer cleared, so restart
    // always begins with a full gap before digit 0 lights.
    always_comb begin
        state_next  = state;
        timer_clear = 1'b0;
        commit      = 1'b0;
        timer_limit = (state == SHOW0 || state == SHOW1) ? DWELL_LIMIT : GAP_LIMIT;
        if (!enable) begin
            state_next  = GAP1;
            timer_clear = 1'b1;
        end else if (timer_tc) begin
            timer_clear = 1'b1;
            case (state)
                SHOW0:   state_next = GAP0;
                GAP0:    state_next = SHOW1;
                SHOW1:   state_next = GAP1;
                default: begin
                    state_next = SHOW0;
                    commit     = 1'b1;
                end
            endcase
        end
    end

    assign load_ready = !pending;
    assign accept     = load_valid && !pending;

    // accept and a pending commit are mutually exclusive because ready is
    // low whenever a pair is waiting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending      <= 1'b0;
            shadow       <= {BLANK_CODE, BLANK_CODE};
            disp0        <= BLANK_CODE;
            disp1        <= BLANK_CODE;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= commit;
            if (commit && pending) begin
                disp0   <= shadow[9:5];
                disp1   <= shadow[4:0];
                pending <= 1'b0;
            end else if (accept) begin
                shadow  <= {first_in, second_in};
                pending <= 1'b1;
            end
        end
    end

    assign frame_done = frame_done_q;

    always_comb begin
        anode_n  = 2'b11;
        seg_code = BLANK_CODE;
        case (state)
            SHOW0: begin
                anode_n  = 2'b10;
                seg_code = disp0;
            end
            SHOW1: begin
                anode_n  = 2'b01;
                seg_code = disp1;
            end
            default: begin
                anode_n  = 2'b11;
                seg_code = BLANK_CODE;
            end
        endcase
    end

endmodule
